// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Timer must hold the larger of the two reload values (N-1), at least 1 bit.
  function automatic int timer_width(input int hold_cycles, input int gap_cycles);
    int longest;
    longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

  function automatic int pending_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; zero flags the final cycle of a phase.
module cycle_timer
  import pulse_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle strobes into HOLD_CYCLES-long levels, queueing overlapping events.
// Optional macro PULSE_RETRIGGER_EN: strobes during HOLD extend the current pulse.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter  int HOLD_CYCLES = 50_000_000,
  parameter  int GAP_CYCLES  = 10_000_000,
  parameter  int MAX_PENDING = 7,
  localparam int PW          = pending_width(MAX_PENDING)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strobe,
  input  logic          clr_ovf,
  output logic          level,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int             TW       = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0]  HOLD_LD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0]  PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0]  PEND_ONE = PW'(1);

  state_t        state;
  state_t        state_nx;
  logic          load;
  logic [TW-1:0] load_val;
  logic          zero;
  logic          enq;
  logic [PW-1:0] pending_nx;
  logic          overflow_nx;

  cycle_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .zero  (zero)
  );

  always_comb begin
    state_nx    = state;
    load        = 1'b0;
    load_val    = HOLD_LD;
    enq         = 1'b0;
    pending_nx  = pending;
    overflow_nx = overflow & ~clr_ovf;

    case (state)
      IDLE: begin
        if (strobe) begin
          state_nx = HOLD;
          load     = 1'b1;
        end
      end
      HOLD: begin
`ifdef PULSE_RETRIGGER_EN
        if (strobe) begin
          load = 1'b1;
        end else if (zero) begin
          state_nx = GAP;
          load     = 1'b1;
          load_val = GAP_LD;
        end
`else
        enq = strobe;
        if (zero) begin
          state_nx = GAP;
          load     = 1'b1;
          load_val = GAP_LD;
        end
`endif
      end
      GAP: begin
        if (!zero) begin
          enq = strobe;
        end else if (pending != '0) begin
          // Replay a queued event; a coincident strobe takes its queue slot.
          state_nx   = HOLD;
          load       = 1'b1;
          pending_nx = pending - PEND_ONE;
          enq        = strobe;
        end else if (strobe) begin
          state_nx = HOLD;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A dropped strobe sets overflow after the clear, so set wins.
    if (enq) begin
      if (pending_nx < PEND_MAX) begin
        pending_nx = pending_nx + PEND_ONE;
      end else begin
        overflow_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      level    <= (state_nx == HOLD);
      busy     <= (state_nx != IDLE);
      pending  <= pending_nx;
      overflow <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized and directed bench for pulse_stretcher against an absolute-time event model.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int M  = 3;
  localparam int PW = $clog2(M + 1);
  localparam int VW = PW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          strobe;
  logic          clr_ovf;
  logic          level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cyc is the index of the current cycle; the active event started at
  // edge m_start, so level spans cycles m_start+1..m_start+H and busy spans
  // m_start+1..m_start+H+G.
  int cyc     = 0;
  int m_start = -1000;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PENDING (M)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (strobe),
    .clr_ovf  (clr_ovf),
    .level    (level),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic model_reset();
    m_start = -1000;
    m_pend  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit c);
    int e;
    bit enq;
    e   = cyc;
    enq = 1'b0;
    if (e > m_start + H + G) begin
      if (s) m_start = e;
    end else if (e <= m_start + H) begin
`ifdef PULSE_RETRIGGER_EN
      if (s) m_start = e;
`else
      enq = s;
`endif
    end else if (e == m_start + H + G) begin
      if (m_pend > 0) begin
        m_start = e;
        m_pend  = m_pend - 1;
        enq     = s;
      end else if (s) begin
        m_start = e;
      end
    end else begin
      enq = s;
    end
    if (c) m_ovf = 1'b0;
    if (enq) begin
      if (m_pend < M) m_pend = m_pend + 1;
      else            m_ovf  = 1'b1;
    end
    cyc = cyc + 1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic lv;
    logic bz;
    logic [PW-1:0] pd;
    bz = (cyc <= m_start + H + G);
    lv = (cyc <= m_start + H);
    pd = m_pend[PW-1:0];
    return {lv, bz, pd, m_ovf};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {level, busy, pending, overflow};
  endfunction

  task automatic step(input bit s, input bit c);
    strobe  = s;
    clr_ovf = c;
    @(posedge clk);
    model_edge(s, c);
    #1;
    strobe  = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++;
      $display("FAIL reset_hold got=%b exp=%b", dut_vec(), {VW{1'b0}});
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    int lv_cnt;
    int bz_cnt;
    lv_cnt = 0;
    bz_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
      if (level) lv_cnt++;
      if (busy)  bz_cnt++;
    end
    n_cmp++;
    if (lv_cnt !== H) begin
      n_bad++;
      $display("FAIL single_level_len got=%0d exp=%0d", lv_cnt, H);
    end
    n_cmp++;
    if (bz_cnt !== H + G) begin
      n_bad++;
      $display("FAIL single_busy_len got=%0d exp=%0d", bz_cnt, H + G);
    end
  endtask

  task automatic test_back_to_back();
    int peak;
    int pulses;
    int lv_cnt;
    logic prev;
    peak   = 0;
    pulses = 0;
    lv_cnt = 0;
    prev   = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(i == 0 || i == 2 || i == 3, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
      if (int'(pending) > peak) peak = int'(pending);
      if (level && !prev) pulses++;
      if (level) lv_cnt++;
      prev = level;
    end
`ifdef PULSE_RETRIGGER_EN
    n_cmp++;
    if (pulses !== 1 || lv_cnt !== 7 || peak !== 0) begin
      n_bad++;
      $display("FAIL b2b_shape got=%0d/%0d/%0d exp=1/7/0", pulses, lv_cnt, peak);
    end
`else
    n_cmp++;
    if (pulses !== 3 || lv_cnt !== 3 * H || peak !== 2) begin
      n_bad++;
      $display("FAIL b2b_shape got=%0d/%0d/%0d exp=3/%0d/2", pulses, lv_cnt, peak, 3 * H);
    end
`endif
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL ovf_fill cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
`ifndef PULSE_RETRIGGER_EN
    n_cmp++;
    if (pending !== PW'(M) || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sat got=%0d/%b exp=%0d/1", pending, overflow, M);
    end
`endif
    step(1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL ovf_drain cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_gap_strobe();
    for (int i = 0; i <= H + G; i++) begin
      step(i == 0 || i == H + G, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gap_strobe cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({level, busy, pending} !== {1'b1, 1'b1, {PW{1'b0}}}) begin
      n_bad++;
      $display("FAIL gap_rehold got=%b%b%0d exp=110", level, busy, pending);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gap_drain cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int lv_cnt;
    lv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL arst_pre cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++;
      $display("FAIL arst_now got=%b exp=%b", dut_vec(), {VW{1'b0}});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL arst_post cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
      if (level) lv_cnt++;
    end
    n_cmp++;
    if (lv_cnt !== 0) begin
      n_bad++;
      $display("FAIL arst_replay got=%0d exp=0", lv_cnt);
    end
  endtask

`ifdef PULSE_RETRIGGER_EN
  task automatic test_retrigger();
    int lv_cnt;
    lv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(i == 0 || i == 3, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL retrig cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
      end
      if (level) lv_cnt++;
    end
    n_cmp++;
    if (lv_cnt !== 7) begin
      n_bad++;
      $display("FAIL retrig_len got=%0d exp=7", lv_cnt);
    end
  endtask
`endif

  task automatic test_random();
    bit s;
    bit c;
    int density;
    for (int i = 0; i < 400; i++) begin
      density = ((i / 50) % 2 == 0) ? 45 : 10;
      s = ($urandom_range(0, 99) < density);
      c = ($urandom_range(0, 99) < 8);
      step(s, c);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc=%0d s=%b c=%b got=%b exp=%b", cyc, s, c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    strobe  = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap_strobe();
    test_async_reset();
`ifdef PULSE_RETRIGGER_EN
    test_retrigger();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
